// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM state encoding, iteration count and
// small sign-handling helpers.
package muldiv_pkg;

    // One result bit per iteration, so a 32-bit operand needs 32 iterations.
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    // Magnitude of a 32-bit value; two's-complement negation only when signed.
    // 0x80000000 maps onto itself, which is still the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Conditional 32-bit two's-complement negation.
    function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single iteration of the multiply/divide datapath (purely combinational).
// Multiply: shift-add on {acc_hi, acc_lo}, multiplier bits consumed from acc_lo[0].
// Divide:   restoring shift-subtract, partial remainder in acc_hi, quotient
//           bits shifted into acc_lo from the right as dividend bits leave on the left.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div_i,
    input  logic [31:0] acc_hi_i,
    input  logic [31:0] acc_lo_i,
    input  logic [31:0] operand_i,
    output logic [31:0] acc_hi_o,
    output logic [31:0] acc_lo_o
);

    logic [32:0] sum;
    logic [32:0] shifted_rem;
    logic        rem_ge;
    logic [31:0] rem_diff;

    // Compute one iteration for whichever operation is in progress.
    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is set,
        // then shift the 65-bit {carry, hi, lo} right by one.
        sum         = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, operand_i} : 33'd0);

        // Divide: bring the next dividend bit into the partial remainder and
        // subtract the divisor if it fits. The remainder is always below the
        // divisor afterwards, so the low 32 bits of the difference are exact.
        shifted_rem = {acc_hi_i, acc_lo_i[31]};
        rem_ge      = (shifted_rem >= {1'b0, operand_i});
        rem_diff    = shifted_rem[31:0] - operand_i;

        if (is_div_i) begin
            if (rem_ge) begin
                acc_hi_o = rem_diff;
                acc_lo_o = {acc_lo_i[30:0], 1'b1};
            end else begin
                acc_hi_o = shifted_rem[31:0];
                acc_lo_o = {acc_lo_i[30:0], 1'b0};
            end
        end else begin
            acc_hi_o = sum[32:1];
            acc_lo_o = {sum[0], acc_lo_i[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with architectural HI/LO.
// Accepts an operation in IDLE, iterates 32 times in RUN, applies sign
// fix-up and writes HI/LO in FIX (done pulses the cycle after).
// Optional feature: define MULDIV_ABORT_EN to add an 'abort' input that
// cancels an in-flight operation without touching HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        hilo_we,
    input  logic        hilo_sel,
`ifdef MULDIV_ABORT_EN
    input  logic        abort,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        acc_hi_q, acc_hi_d;
    logic [31:0]        acc_lo_q, acc_lo_d;
    logic [31:0]        opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [31:0]        dvd_q, dvd_d;        // raw dividend, returned in HI on divide-by-zero
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d; // negate product / quotient
    logic               neg_rem_q, neg_rem_d; // negate remainder
    logic               divz_q, divz_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic               op_div;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        step_hi;
    logic [31:0]        step_lo;
    logic [63:0]        prod_fixed;
    logic [31:0]        quo_fixed;
    logic [31:0]        rem_fixed;
    logic               abort_hit;

    muldiv_step u_step (
        .is_div_i  (is_div_q),
        .acc_hi_i  (acc_hi_q),
        .acc_lo_i  (acc_lo_q),
        .operand_i (opnd_q),
        .acc_hi_o  (step_hi),
        .acc_lo_o  (step_lo)
    );

    // Decode the requested operation and form operand magnitudes for capture.
    always_comb begin
        op_signed = 1'b0;
        op_div    = 1'b0;
        unique case (op_e'(op))
            OP_MULT:  begin op_signed = 1'b1; op_div = 1'b0; end
            OP_MULTU: begin op_signed = 1'b0; op_div = 1'b0; end
            OP_DIV:   begin op_signed = 1'b1; op_div = 1'b1; end
            OP_DIVU:  begin op_signed = 1'b0; op_div = 1'b1; end
        endcase
        a_mag = mag32(srca, op_signed);
        b_mag = mag32(srcb, op_signed);
    end

    // Final sign fix-up applied to the accumulated magnitudes in FIX.
    always_comb begin
        prod_fixed = neg_res_q ? (~{acc_hi_q, acc_lo_q} + 64'd1) : {acc_hi_q, acc_lo_q};
        quo_fixed  = cneg32(acc_lo_q, neg_res_q);
        rem_fixed  = cneg32(acc_hi_q, neg_rem_q);
    end

    // Abort only matters once an operation has been accepted.
`ifdef MULDIV_ABORT_EN
    assign abort_hit = abort && (state_q != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Next-state and datapath update for the IDLE -> RUN -> FIX sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        dvd_d     = dvd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Direct writes only land while idle; a same-edge start is
                // still accepted and its result overwrites both registers later.
                if (hilo_we) begin
                    if (hilo_sel) hi_d = srca;
                    else          lo_d = srca;
                end
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    is_div_d  = op_div;
                    neg_res_d = op_signed && (srca[31] ^ srcb[31]);
                    neg_rem_d = op_signed && op_div && srca[31];
                    divz_d    = (srcb == 32'd0);
                    dvd_d     = srca;
                    acc_hi_d  = 32'd0;
                    if (op_div) begin
                        acc_lo_d = a_mag;
                        opnd_d   = b_mag;
                    end else begin
                        acc_lo_d = b_mag;
                        opnd_d   = a_mag;
                    end
                end
            end
            ST_RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fixed[63:32];
                    lo_d = prod_fixed[31:0];
                end else if (divz_q) begin
                    hi_d = dvd_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quo_fixed;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort beats a same-cycle FIX completion: no write, no done.
        if (abort_hit) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, counter and architectural HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            acc_hi_q  <= 32'd0;
            acc_lo_q  <= 32'd0;
            opnd_q    <= 32'd0;
            dvd_q     <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            dvd_q     <= dvd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, named as in the codebase, listed first: clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-002 SHALL have port srca, in, 32, first operand (multiplicand / dividend), driven by the same source as the ALU A input.
REQ-003 SHALL have port srcb, in, 32, second operand (multiplier / divisor), driven by the same source as the ALU B input.
REQ-004 SHALL have port start, in, 1, single-cycle operation request.
REQ-005 SHALL have port op, in, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port hilo_we, in, 1, direct write strobe (MTHI/MTLO).
REQ-007 SHALL have port hilo_sel, in, 1: 0 selects LO, 1 selects HI, for hilo_we.
REQ-008 SHALL have ports hi and lo, out, 32 each, architectural HI/LO registers.
REQ-009 SHALL have port busy, out, 1, high while an operation is in flight.
REQ-010 SHALL have port done, out, 1, one-cycle pulse when hi/lo receive a result.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and FIX.
- IDLE->RUN on start sampled high in IDLE.
- RUN->FIX after 32 iteration edges.
- FIX->IDLE on the next edge.
REQ-012 SHALL capture srca, srcb and op on the accepting edge (edge 0); later changes to these inputs have no effect.
REQ-013 SHALL run iterations on edges 1..32 and write hi/lo on edge 33. done is high for exactly the cycle following edge 33. busy is high whenever state != IDLE.
REQ-014 SHALL implement multiplication as a 1-bit/iteration shift-add on operand magnitudes; the signed (MULT) 64-bit product is negated in FIX when operand signs differ; hi={product[63:32]}, lo={product[31:0]}.
REQ-015 SHALL implement division as a 1-bit/iteration restoring divide on magnitudes. For DIV:
- quotient is negated when signs differ;
- remainder takes the dividend's sign;
- lo=quotient, hi=remainder.
REQ-016 SHALL, on divisor zero, produce lo=32'hFFFFFFFF and hi=dividend (as captured), with no trap, at the normal latency.
REQ-017 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0.
REQ-018 SHALL ignore start while busy is high.
REQ-019 SHALL ignore hilo_we while busy is high.
REQ-020 SHALL, when hilo_we and start are both high in IDLE, perform the write on that edge and also accept start; the later result overwrites both registers.
REQ-021 SHALL, on hilo_we in IDLE, load srca into the register selected by hilo_sel.

Reset
REQ-022 SHALL, on reset_n low, immediately (asynchronously) force state=IDLE, hi=0, lo=0, busy=0, done=0, and clear the iteration counter and internal accumulators.
REQ-023 SHALL abandon any in-flight operation on reset mid-operation; no done pulse follows reset release.

Configuration
REQ-024 SHALL use macro MULDIV_ABORT_EN. When defined, the module has an input abort (1 bit). abort high in RUN or FIX returns the FSM to IDLE on that edge, leaving hi/lo unchanged and producing no done; abort in IDLE has no effect; abort wins over a same-cycle FIX completion.
REQ-025 SHALL, when MULDIV_ABORT_EN is undefined, omit the abort port and let every accepted operation complete.

Structure
REQ-026 SHALL place the op encodings, the FSM state encoding and the ITER=32 constant in shared package muldiv_pkg.
REQ-027 SHALL factor one combinational sub-module, muldiv_step, that performs a single shift-add or shift-subtract iteration; it is instantiated once.

Verification
REQ-028 SHALL cover MULT 0xFFFFFFFF x 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; done exactly 34 cycles after the start cycle; busy high for 33 cycles.
REQ-029 SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 SHALL cover DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 SHALL cover DIVU 0x00000064 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-032 SHALL cover start re-pulsed at cycle 5 while busy -> ignored, with the first result intact; hilo_we during busy -> ignored.
REQ-033 SHALL cover reset_n low at cycle 10 of a DIVU -> hi, lo, busy and done become 0 without a clock edge, and no done follows reset release. With MULDIV_ABORT_EN defined: abort at cycle 5 -> hi/lo keep prior values, and done stays 0.
